// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
//
// Contents:
//   tx_state_t         - transmitter FSM states (IDLE, START, DATA, STOP)
//   STAT_BUSY/FULL/OVF - bit positions inside the status word
//   DEFAULT_*_ADDR     - default MMIO addresses for the TX data and status registers
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int STAT_BUSY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVF  = 2;

    localparam logic [15:0] DEFAULT_TX_ADDR   = 16'hFF02;
    localparam logic [15:0] DEFAULT_STAT_ADDR = 16'hFF03;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//
// The head entry is always visible on dout, so a consumer can read and pop it
// on the same edge. Intended to be shared by the UART TX and a future UART RX.
//
// Parameters:
//   WIDTH - bits per entry
//   DEPTH - number of entries, power of 2 and at least 2
//
// Ports:
//   clock - system clock
//   reset - synchronous, active-low reset (empties the FIFO)
//   push  - write din this edge; ignored when full unless pop is also taken
//   pop   - drop the head entry this edge; ignored when empty
//   din   - data to write
//   dout  - head entry (undefined when empty)
//   full  - count == DEPTH
//   empty - count == 0
//   count - number of stored entries
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW:0]      count_q, count_d;

    logic popEn;
    logic pushEn;

    // A pop only happens when something is stored. A push into a full FIFO is
    // still accepted when the head leaves on the same edge, because that frees
    // the slot the write pointer is about to reuse.
    assign popEn  = pop && !empty;
    assign pushEn = push && (!full || popEn);

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rdPtr_q];

    // Pointer and occupancy next-state. DEPTH is a power of 2, so the pointers
    // wrap modulo DEPTH simply by overflowing their AW bits.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushEn) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({pushEn, popEn})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset empties the FIFO without touching storage.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers, so it
    // needs no reset.
    always_ff @(posedge clock) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= din;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
//
// Stores to TX_ADDR queue a byte in a FIFO; the FSM pops bytes and shifts them
// out LSB first with one start and one stop bit. Reading STAT_ADDR returns
// {13'b0, overflow, full, busy}; a store to STAT_ADDR clears the sticky overflow.
//
// Ports:
//   clock      - system clock
//   reset      - synchronous, active-low reset
//   mmio_addr  - core data address
//   mmio_data  - core store data, bits [7:0] are the byte to send
//   mmio_write - one-cycle store strobe
//   mmio_rdata - status word when mmio_addr == STAT_ADDR, else 0
//   uart_tx    - registered serial line, idle high
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLK_FREQ     = 27000000,
    parameter int          BAUD         = 115200,
    parameter int          CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter logic [15:0] TX_ADDR      = DEFAULT_TX_ADDR,
    parameter logic [15:0] STAT_ADDR    = DEFAULT_STAT_ADDR,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] mmio_addr,
    input  logic [15:0] mmio_data,
    input  logic        mmio_write,
    output logic [15:0] mmio_rdata,
    output logic        uart_tx
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baudCnt_q, baudCnt_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic [7:0]    shiftReg_q, shiftReg_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;

    logic                        txPush;
    logic                        statWrite;
    logic                        fifoPop;
    logic                        fifoFull;
    logic                        fifoEmpty;
    logic [7:0]                  fifoDout;
    logic                        busy;
    logic                        baudLast;
    logic [2:0]                  bitNext;
    logic [$clog2(FIFO_DEPTH):0] unusedFifoCount;
    logic                        unusedDataBits;

    assign txPush    = mmio_write && (mmio_addr == TX_ADDR);
    assign statWrite = mmio_write && (mmio_addr == STAT_ADDR);
    assign fifoPop   = (state_q == IDLE) && !fifoEmpty;
    assign busy      = (state_q != IDLE) || !fifoEmpty;
    assign baudLast  = (baudCnt_q == BAUD_LAST);
    assign bitNext   = bitIdx_q + 3'd1;
    assign uart_tx   = tx_q;

    assign unusedDataBits = ^mmio_data[15:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (txPush),
        .pop   (fifoPop),
        .din   (mmio_data[7:0]),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (unusedFifoCount)
    );

    // Sticky overflow. A dropped byte is one pushed while full with no pop on
    // the same edge. The set is evaluated after the clear so a drop that
    // coincides with a status store still leaves the flag raised.
    always_comb begin
        overflow_d = overflow_q;
        if (statWrite) begin
            overflow_d = 1'b0;
        end
        if (txPush && fifoFull && !fifoPop) begin
            overflow_d = 1'b1;
        end
    end

    // Transmit FSM next-state. tx_d is the line level for the state being
    // entered, so uart_tx comes straight from a flop and changes exactly on the
    // edge the state changes. The baud counter restarts at every bit boundary.
    always_comb begin
        state_d    = state_q;
        baudCnt_d  = baudCnt_q;
        bitIdx_d   = bitIdx_q;
        shiftReg_d = shiftReg_q;
        tx_d       = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifoEmpty) begin
                    shiftReg_d = fifoDout;
                    baudCnt_d  = '0;
                    bitIdx_d   = 3'd0;
                    state_d    = START;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (baudLast) begin
                    baudCnt_d = '0;
                    bitIdx_d  = 3'd0;
                    state_d   = DATA;
                    tx_d      = shiftReg_q[0];
                end else begin
                    baudCnt_d = baudCnt_q + BW'(1);
                end
            end
            DATA: begin
                if (baudLast) begin
                    baudCnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bitIdx_d = bitNext;
                        tx_d     = shiftReg_q[bitNext];
                    end
                end else begin
                    baudCnt_d = baudCnt_q + BW'(1);
                end
            end
            STOP: begin
                if (baudLast) begin
                    baudCnt_d = '0;
                    state_d   = IDLE;
                    tx_d      = 1'b1;
                end else begin
                    baudCnt_d = baudCnt_q + BW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                baudCnt_d = '0;
                bitIdx_d  = 3'd0;
                tx_d      = 1'b1;
            end
        endcase
    end

    // State registers. Reset returns the line high at once, even mid-frame.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            baudCnt_q  <= '0;
            bitIdx_q   <= 3'd0;
            shiftReg_q <= 8'h00;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baudCnt_q  <= baudCnt_d;
            bitIdx_q   <= bitIdx_d;
            shiftReg_q <= shiftReg_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    // Status read port: combinational decode of the address over registered
    // state only, so it never depends on the store strobe.
    always_comb begin
        mmio_rdata = 16'h0000;
        if (mmio_addr == STAT_ADDR) begin
            mmio_rdata[STAT_BUSY] = busy;
            mmio_rdata[STAT_FULL] = fifoFull;
            mmio_rdata[STAT_OVF]  = overflow_q;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with a short bit time.
//
// A line monitor captures every frame sample by sample and compares it with
// the waveform expected for the next byte in the scoreboard queue. The main
// sequence pushes a byte into the queue whenever it stores one that should be
// transmitted, and checks status words and line levels at chosen cycles.
module tb_mmio_uart_tx;

    localparam int          CPB          = 4;
    localparam int          DEPTH        = 8;
    localparam int          FRAME_CYCLES = 10 * CPB;
    localparam logic [15:0] TXA          = 16'hFF02;
    localparam logic [15:0] STA          = 16'hFF03;

    logic        clock      = 1'b0;
    logic        reset      = 1'b0;
    logic [15:0] mmio_addr  = 16'hFF02;
    logic [15:0] mmio_data  = 16'h0000;
    logic        mmio_write = 1'b0;
    logic [15:0] mmio_rdata;
    logic        uart_tx;

    int total = 0;
    int bad   = 0;

    logic [7:0] sbQueue[$];
    int         startTimes[$];
    int         cycleCount = 0;

    always #5 clock = ~clock;

    mmio_uart_tx #(
        .CLK_FREQ     (27000000),
        .BAUD         (115200),
        .CLKS_PER_BIT (CPB),
        .TX_ADDR      (TXA),
        .STAT_ADDR    (STA),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mmio_addr  (mmio_addr),
        .mmio_data  (mmio_data),
        .mmio_write (mmio_write),
        .mmio_rdata (mmio_rdata),
        .uart_tx    (uart_tx)
    );

    // Advance n rising edges, leaving time just past the last edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One store cycle; address returns to the status register afterwards.
    task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data);
        mmio_addr  = addr;
        mmio_data  = data;
        mmio_write = 1'b1;
        tick(1);
        mmio_write = 1'b0;
        mmio_addr  = STA;
        #1;
    endtask

    task automatic storeByte(input logic [15:0] data, input bit expectSent);
        if (expectSent) begin
            sbQueue.push_back(data[7:0]);
        end
        applyStimulus(TXA, data);
    endtask

    task automatic waitDrain(input int budget, input string tag);
        int n;
        n = 0;
        while (sbQueue.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(tag, 32'(sbQueue.size()), 32'd0);
        tick(2);
    endtask

    // Line monitor: samples once per cycle on the falling edge.
    initial begin : lineMonitor
        logic [39:0] obsFrame;
        logic [39:0] expFrame;
        logic [9:0]  frame10;
        logic [7:0]  expByte;
        int          sampleIdx;
        bit          inFrame;
        inFrame   = 1'b0;
        sampleIdx = 0;
        forever begin
            @(negedge clock);
            cycleCount++;
            if (!reset) begin
                inFrame = 1'b0;
                continue;
            end
            if (!inFrame && uart_tx === 1'b0) begin
                inFrame   = 1'b1;
                sampleIdx = 0;
                startTimes.push_back(cycleCount);
            end
            if (inFrame) begin
                obsFrame[sampleIdx] = uart_tx;
                sampleIdx++;
                if (sampleIdx == FRAME_CYCLES) begin
                    inFrame = 1'b0;
                    total++;
                    assert (sbQueue.size() != 0) else begin
                        bad++;
                        $error("[TB] FAIL unexpectedFrame observed=%h expected=no frame", obsFrame);
                    end
                    if (sbQueue.size() != 0) begin
                        expByte = sbQueue.pop_front();
                        frame10 = {1'b1, expByte, 1'b0};
                        for (int k = 0; k < FRAME_CYCLES; k++) begin
                            expFrame[k] = frame10[k / CPB];
                        end
                        total++;
                        assert (obsFrame === expFrame) else begin
                            bad++;
                            $error("[TB] FAIL frame byte=%h observed=%h expected=%h",
                                   expByte, obsFrame, expFrame);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : mainSequence
        int busyMiss;

        // Reset held with a store pending: nothing may be queued.
        reset      = 1'b0;
        mmio_write = 1'b1;
        mmio_addr  = TXA;
        mmio_data  = 16'h0055;
        tick(3);
        checkOutput("rstLine", {31'b0, uart_tx}, 32'd1);
        reset      = 1'b1;
        mmio_write = 1'b0;
        mmio_addr  = STA;
        #1;
        checkOutput("rstStatus", {16'h0, mmio_rdata}, 32'h0);
        tick(5);
        checkOutput("rstIdleLine", {31'b0, uart_tx}, 32'd1);
        checkOutput("rstIdleStatus", {16'h0, mmio_rdata}, 32'h0);

        // Single frame: start bit after the pop edge, busy for the whole frame.
        storeByte(16'h1255, 1'b1);
        checkOutput("t2LineAfterStore", {31'b0, uart_tx}, 32'd1);
        checkOutput("t2BusyAfterStore", {16'h0, mmio_rdata}, 32'h1);
        tick(1);
        checkOutput("t2StartBit", {31'b0, uart_tx}, 32'd0);
        busyMiss = 0;
        for (int i = 0; i < FRAME_CYCLES - 1; i++) begin
            tick(1);
            if (mmio_rdata !== 16'h0001) begin
                busyMiss++;
            end
        end
        checkOutput("t2BusyThroughout", 32'(busyMiss), 32'd0);
        tick(1);
        checkOutput("t2StatusAfterStop", {16'h0, mmio_rdata}, 32'h0);
        checkOutput("t2Drained", 32'(sbQueue.size()), 32'd0);

        // Three back-to-back bytes with a one-cycle idle gap between frames.
        startTimes.delete();
        storeByte(16'h00A1, 1'b1);
        storeByte(16'h00B2, 1'b1);
        storeByte(16'h00C3, 1'b1);
        waitDrain(300, "t3Drain");
        checkOutput("t3FrameCount", 32'(startTimes.size()), 32'd3);
        if (startTimes.size() == 3) begin
            checkOutput("t3Gap1", 32'(startTimes[1] - startTimes[0]), 32'(FRAME_CYCLES + 1));
            checkOutput("t3Gap2", 32'(startTimes[2] - startTimes[1]), 32'(FRAME_CYCLES + 1));
        end

        // Overflow: one byte in flight, nine stores, the ninth is dropped.
        storeByte(16'h00D0, 1'b1);
        tick(1);
        for (int i = 0; i < 9; i++) begin
            storeByte(16'h0010 + 16'(i), (i < DEPTH));
        end
        checkOutput("t4OvfStatus", {16'h0, mmio_rdata}, 32'h7);
        applyStimulus(STA, 16'h0000);
        checkOutput("t4ClearStatus", {16'h0, mmio_rdata}, 32'h3);
        waitDrain(600, "t4Drain");
        checkOutput("t4IdleStatus", {16'h0, mmio_rdata}, 32'h0);

        // Full FIFO: push lands on the same edge as the FSM pop.
        storeByte(16'h00E0, 1'b1);
        for (int i = 1; i <= DEPTH; i++) begin
            storeByte(16'h00E0 + 16'(i), 1'b1);
        end
        tick(FRAME_CYCLES - DEPTH + 1);
        checkOutput("t6PrePopLine", {31'b0, uart_tx}, 32'd1);
        checkOutput("t6PrePopStatus", {16'h0, mmio_rdata}, 32'h3);
        storeByte(16'h00EF, 1'b1);
        checkOutput("t6PushPopStatus", {16'h0, mmio_rdata}, 32'h3);
        checkOutput("t6PopLine", {31'b0, uart_tx}, 32'd0);
        waitDrain(600, "t6Drain");
        checkOutput("t6IdleStatus", {16'h0, mmio_rdata}, 32'h0);

        // Reset during data bit 3 aborts the frame and flushes queued bytes.
        storeByte(16'h0035, 1'b0);
        storeByte(16'h0066, 1'b0);
        storeByte(16'h0077, 1'b0);
        tick(15);
        checkOutput("t5Bit3Line", {31'b0, uart_tx}, 32'd0);
        reset = 1'b0;
        tick(1);
        checkOutput("t5AbortLine", {31'b0, uart_tx}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("t5RstStatus", {16'h0, mmio_rdata}, 32'h0);
        tick(4);
        checkOutput("t5IdleLine", {31'b0, uart_tx}, 32'd1);
        checkOutput("t5IdleStatus", {16'h0, mmio_rdata}, 32'h0);
        storeByte(16'h005A, 1'b1);
        waitDrain(200, "t5Drain");
        checkOutput("t5FinalStatus", {16'h0, mmio_rdata}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
